// File: rtl/rx_buffer_ctrl.sv
// rtl/rx_buffer_ctrl.sv - receive FIFO with sticky overrun and framing-error flags
module rx_buffer_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_buffer,
    input  logic [DATA_W-1:0]       packet_data,
    input  logic                    fe_event,
    input  logic                    data_read,
    output logic [DATA_W-1:0]       rx_data,
    output logic                    data_ready,
    output logic                    overrun_error,
    output logic                    framing_error,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic fifo_empty;
    logic fifo_full;
    logic pop_ok;
    logic push_ok;
    logic overrun_set;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a push when the host reads at the same time.
    always_comb begin
        fifo_empty  = (count == '0);
        fifo_full   = (count == CNT_W'(DEPTH));
        pop_ok      = data_read && !fifo_empty;
        push_ok     = load_buffer && (!fifo_full || pop_ok);
        overrun_set = load_buffer && !push_ok;
    end

    // Storage is not reset; entries are invisible while count is zero.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= packet_data;
        end
    end

    // Pointers and occupancy; pointers wrap explicitly from DEPTH-1 to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Sticky error flags: set has priority over the clear caused by a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun_error <= 1'b1;
            end else if (pop_ok) begin
                overrun_error <= 1'b0;
            end
            if (fe_event) begin
                framing_error <= 1'b1;
            end else if (pop_ok) begin
                framing_error <= 1'b0;
            end
        end
    end

    // Head of FIFO is presented without a register stage; zero when empty.
    always_comb begin
        rx_data    = fifo_empty ? '0 : mem[rd_ptr];
        data_ready = !fifo_empty;
    end

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// tb/tb_rx_buffer_ctrl.sv - self-checking bench for rx_buffer_ctrl against a queue model
module tb_rx_buffer_ctrl;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       load_buffer;
    logic [7:0] packet_data;
    logic       fe_event;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    logic [7:0] mq[$];
    logic       m_ovr = 1'b0;
    logic       m_fer = 1'b0;

    rx_buffer_ctrl #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_buffer   (load_buffer),
        .packet_data   (packet_data),
        .fe_event      (fe_event),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the queue model.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("cmp_count", {29'b0, count}, mq.size());
                chk("cmp_ready", {31'b0, data_ready}, (mq.size() != 0) ? 1 : 0);
                chk("cmp_rx_data", {24'b0, rx_data}, (mq.size() != 0) ? {24'b0, mq[0]} : 0);
                chk("cmp_overrun", {31'b0, overrun_error}, {31'b0, m_ovr});
                chk("cmp_framing", {31'b0, framing_error}, {31'b0, m_fer});
            end
        end
    end

    // Drive one cycle of inputs and advance the model by the FIFO rules.
    task automatic step(input logic r, input logic lb, input logic [7:0] d,
                        input logic fe, input logic rd);
        bit pop_ok;
        bit push_ok;
        bit drop;
        @(negedge clk);
        rst         = r;
        load_buffer = lb;
        packet_data = d;
        fe_event    = fe;
        data_read   = rd;
        pop_ok  = rd && (mq.size() > 0);
        push_ok = lb && ((mq.size() < DEPTH) || pop_ok);
        drop    = lb && !push_ok;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            m_ovr = 1'b0;
            m_fer = 1'b0;
        end else begin
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back(d);
            if (drop) m_ovr = 1'b1;
            else if (pop_ok) m_ovr = 1'b0;
            if (fe) m_fer = 1'b1;
            else if (pop_ok) m_fer = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; load_buffer = 1'b0; packet_data = 8'h00;
        fe_event = 1'b0; data_read = 1'b0;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_en = 1;
        chk("rst_count", {29'b0, count}, 0);
        chk("rst_ready", {31'b0, data_ready}, 0);
        chk("rst_rx_data", {24'b0, rx_data}, 0);
        chk("rst_flags", {30'b0, overrun_error, framing_error}, 0);

        // Single byte through.
        push(8'hA5);
        chk("a5_count", {29'b0, count}, 1);
        chk("a5_ready", {31'b0, data_ready}, 1);
        chk("a5_rx_data", {24'b0, rx_data}, 32'hA5);
        pop();
        chk("a5_pop_count", {29'b0, count}, 0);
        chk("a5_pop_rx_data", {24'b0, rx_data}, 0);

        // Fill, overrun, drain in order.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h55);
        chk("ovr_count", {29'b0, count}, 4);
        chk("ovr_flag", {31'b0, overrun_error}, 1);
        chk("ovr_head", {24'b0, rx_data}, 32'h11);
        pop();
        chk("ovr_cleared", {31'b0, overrun_error}, 0);
        chk("drain_22", {24'b0, rx_data}, 32'h22);
        pop();
        chk("drain_33", {24'b0, rx_data}, 32'h33);
        pop();
        chk("drain_44", {24'b0, rx_data}, 32'h44);
        pop();
        chk("drain_empty", {29'b0, count}, 0);

        // Full with simultaneous push and pop.
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        step(1'b0, 1'b1, 8'h66, 1'b0, 1'b1);
        chk("full_pp_count", {29'b0, count}, 4);
        chk("full_pp_ovr", {31'b0, overrun_error}, 0);
        chk("full_pp_head", {24'b0, rx_data}, 32'h02);
        pop(); pop(); pop();
        chk("full_pp_last", {24'b0, rx_data}, 32'h66);
        pop();

        // Empty with simultaneous push and pop; pop on empty ignored.
        step(1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
        chk("empty_pp_count", {29'b0, count}, 1);
        chk("empty_pp_rx", {24'b0, rx_data}, 32'h77);
        pop();
        pop();
        chk("empty_pop_count", {29'b0, count}, 0);

        // Framing error behaviour.
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fe_empty_count", {29'b0, count}, 0);
        chk("fe_set", {31'b0, framing_error}, 1);
        pop();
        chk("fe_empty_pop_keeps", {31'b0, framing_error}, 1);
        push(8'h10);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fe_count_same", {29'b0, count}, 1);
        push(8'h20);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("fe_pop_set_wins", {31'b0, framing_error}, 1);
        chk("fe_pop_head", {24'b0, rx_data}, 32'h20);
        pop();
        chk("fe_pop_clears", {31'b0, framing_error}, 0);

        // Pointer wrap with continuous traffic at count 3.
        push(8'hC0); push(8'hC1); push(8'hC2);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'hD0 + 8'(i), 1'b0, 1'b1);
        end
        chk("wrap_count", {29'b0, count}, 3);
        chk("wrap_head", {24'b0, rx_data}, 32'hD7);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
        chk("mid_rst_count", {29'b0, count}, 0);
        chk("mid_rst_ready", {31'b0, data_ready}, 0);
        chk("mid_rst_flags", {30'b0, overrun_error, framing_error}, 0);
        push(8'h5A);
        chk("post_rst_head", {24'b0, rx_data}, 32'h5A);

        // Overrun flag cleared by reset.
        push(8'h5B); push(8'h5C); push(8'h5D);
        push(8'hBB);
        chk("pre_rst_ovr", {31'b0, overrun_error}, 1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_ovr_clear", {31'b0, overrun_error}, 0);
        chk("rst_ovr_count", {29'b0, count}, 0);

        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
